// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg
//   Shared register map and bit positions for the pwm_bank PWM controller.
//   Ports: none (package).
package pwm_bank_pkg;

  // Word addresses on the avs_* bus
  localparam logic [4:0] ADDR_CTRL     = 5'd0;
  localparam logic [4:0] ADDR_PRESCALE = 5'd1;
  localparam logic [4:0] ADDR_PERIOD   = 5'd2;
  localparam logic [4:0] ADDR_POLARITY = 5'd3;
  localparam logic [4:0] ADDR_STATUS   = 5'd4;
  localparam logic [4:0] ADDR_DUTY0    = 5'd8;   // DUTY[i] lives at ADDR_DUTY0 + i

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_CH_EN_LSB  = 16;

  // STATUS bit positions
  localparam int STATUS_WRAP_BIT = 0;

  localparam int PRESCALE_W = 16;

endpackage

// File: rtl/pwm_bank_channel.sv
// pwm_bank_channel
//   One PWM channel: active-duty shadow register, compare against the shared
//   period counter, polarity inversion and registered output.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     en        - global enable (CTRL.EN)
//     ch_en     - this channel's enable (CTRL.CH_EN[i])
//     load      - copy duty into the active shadow this edge
//     duty      - DUTY[i] register value
//     cnt       - shared period counter
//     polarity  - POLARITY[i]; inactive output level
//     pwm       - registered PWM output
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ch_en,
  input  logic             load,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt,
  input  logic             polarity,
  output logic             pwm
);

  logic [CNT_W-1:0] active_duty;
  logic             raw;

  // DUTY > PERIOD keeps cnt below active_duty for the whole period, so the
  // channel sits at its active level; DUTY = 0 never compares true.
  assign raw = en & ch_en & (cnt < active_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_duty <= '0;
      pwm         <= 1'b0;
    end else begin
      if (load) active_duty <= duty;
      pwm <= raw ^ polarity;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank
//   Bank of NUM_CH PWM channels sharing one prescaler and period counter,
//   configured through a small register file on an Avalon-MM style slave.
//   Ports:
//     clk_clk        - sole clock
//     reset_reset    - asynchronous active-high reset
//     avs_address    - word address
//     avs_write      - write strobe, avs_writedata - write data
//     avs_read       - read strobe, avs_readdata - registered read data (latency 1)
//     pwm_out        - registered PWM outputs
//     irq            - STATUS.WRAP & CTRL.IRQ_EN
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [4:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              irq
);

  // Register file
  logic                  en;
  logic                  irq_en;
  logic [NUM_CH-1:0]     ch_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [CNT_W-1:0]      period;
  logic [NUM_CH-1:0]     polarity;
  logic                  wrap_flag;
  logic [CNT_W-1:0]      duty [NUM_CH];

  // Timebase
  logic [PRESCALE_W-1:0] psc;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      active_period;
  logic                  tick;
  logic                  wrap;
  logic                  load;

  logic [31:0]           rdata_next;
  logic                  unused_wdata;

  // Only some write-data bits are decoded; fold the rest away.
  assign unused_wdata = &{1'b0, avs_writedata};

  // ">=" rather than "==": if PRESCALE is lowered below the running count,
  // the current interval ends at once instead of running through 2^16.
  assign tick = en && (psc >= prescale);
  assign wrap = tick && (cnt == active_period);
  // While disabled the shadows follow their registers, so enabling starts
  // from fresh values.
  assign load = wrap || !en;

  assign irq = wrap_flag & irq_en;

  // Register writes
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      ch_en    <= '0;
      prescale <= '0;
      period   <= '0;
      polarity <= '0;
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_CTRL: begin
          en     <= avs_writedata[CTRL_EN_BIT];
          irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
          ch_en  <= avs_writedata[CTRL_CH_EN_LSB +: NUM_CH];
        end
        ADDR_PRESCALE: prescale <= avs_writedata[PRESCALE_W-1:0];
        ADDR_PERIOD:   period   <= avs_writedata[CNT_W-1:0];
        ADDR_POLARITY: polarity <= avs_writedata[NUM_CH-1:0];
        default: begin
          for (int i = 0; i < NUM_CH; i++)
            if (avs_address == ADDR_DUTY0 + 5'(i)) duty[i] <= avs_writedata[CNT_W-1:0];
        end
      endcase
    end
  end

  // STATUS.WRAP: a wrap on the same edge as a write-1-to-clear wins.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wrap_flag <= 1'b0;
    end else if (wrap) begin
      wrap_flag <= 1'b1;
    end else if (avs_write && avs_address == ADDR_STATUS && avs_writedata[STATUS_WRAP_BIT]) begin
      wrap_flag <= 1'b0;
    end
  end

  // Prescaler, period counter and active period
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      psc           <= '0;
      cnt           <= '0;
      active_period <= '0;
    end else if (!en) begin
      psc           <= '0;
      cnt           <= '0;
      active_period <= period;
    end else begin
      psc <= tick ? '0 : psc + 16'd1;
      if (tick) cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (wrap) active_period <= period;
    end
  end

  // Read mux and registered read data
  always_comb begin
    rdata_next = '0;
    case (avs_address)
      ADDR_CTRL: begin
        rdata_next[CTRL_EN_BIT]               = en;
        rdata_next[CTRL_IRQ_EN_BIT]           = irq_en;
        rdata_next[CTRL_CH_EN_LSB +: NUM_CH]  = ch_en;
      end
      ADDR_PRESCALE: rdata_next[PRESCALE_W-1:0] = prescale;
      ADDR_PERIOD:   rdata_next[CNT_W-1:0]      = period;
      ADDR_POLARITY: rdata_next[NUM_CH-1:0]     = polarity;
      ADDR_STATUS:   rdata_next[STATUS_WRAP_BIT] = wrap_flag;
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (avs_address == ADDR_DUTY0 + 5'(i)) rdata_next[CNT_W-1:0] = duty[i];
      end
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rdata_next;
  end

  // Channels
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_bank_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .en       (en),
      .ch_en    (ch_en[i]),
      .load     (load),
      .duty     (duty[i]),
      .cnt      (cnt),
      .polarity (polarity[i]),
      .pwm      (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank
//   Directed self-checking bench for pwm_bank (NUM_CH=4, CNT_W=8).
//   Timing convention: inputs change and outputs are sampled 1 time unit
//   after a rising edge; "k" is the number of edges since the enabling write.
module tb_pwm_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [3:0]  pwm_out;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int e0      = 0;
  logic [31:0] rdv;
  logic        exp_b;

  pwm_bank #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .pwm_out       (pwm_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int k);
    while (cyc - e0 < k) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    avs_read      = 1'b0;

    // Reset
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", avs_readdata, 32'h0);
    rst = 1'b0;
    step();

    // Register readback, unused bits and unmapped addresses
    rd(5'd0, rdv);                 check("rb_ctrl_reset", rdv, 32'h0);
    wr(5'd1, 32'hFFFF_ABCD);
    rd(5'd1, rdv);                 check("rb_prescale", rdv, 32'h0000_ABCD);
    wr(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, rdv);                 check("rb_unmapped5", rdv, 32'h0);
    wr(5'd12, 32'h5);
    rd(5'd12, rdv);                check("rb_unmapped12", rdv, 32'h0);
    wr(5'd2, 32'h1FF);
    rd(5'd2, rdv);                 check("rb_period", rdv, 32'h0000_00FF);
    step();
    check("rb_hold", avs_readdata, 32'h0000_00FF);
    check("no_tick_without_en", 32'(pwm_out), 32'h0);
    wr(5'd1, 32'h0);

    // Scenario 1: PERIOD=9, PRESCALE=0, DUTY0=3 -> 3 high of every 10
    wr(5'd2, 32'd9);
    wr(5'd8, 32'd3);
    wr(5'd0, 32'h0001_0001);
    e0 = cyc;
    check("s1_k0", 32'(pwm_out), 32'h0);
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_b = ((k - 1) % 10) < 3;
      check($sformatf("s1_pwm_k%0d", k), 32'(pwm_out), 32'({3'b000, exp_b}));
    end
    rd(5'd4, rdv);                 check("s1_wrap_set", rdv, 32'h1);
    wr(5'd4, 32'h1);
    rd(5'd4, rdv);                 check("s1_wrap_cleared", rdv, 32'h0);
    check("s1_irq_masked", 32'(irq), 32'h0);
    step_to(29);
    rd(5'd4, rdv);                 check("s1_wrap_k30_before", rdv, 32'h0);
    rd(5'd4, rdv);                 check("s1_wrap_k30_after", rdv, 32'h1);

    // Scenario 2: PRESCALE=4, PERIOD=3, DUTY1=2 -> 20-clock period, 10 high
    wr(5'd0, 32'h0);
    wr(5'd1, 32'd4);
    wr(5'd2, 32'd3);
    wr(5'd9, 32'd2);
    wr(5'd0, 32'h0002_0001);
    e0 = cyc;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_b = ((k - 1) % 20) < 10;
      check($sformatf("s2_pwm_k%0d", k), 32'(pwm_out), 32'({2'b00, exp_b, 1'b0}));
    end

    // Scenario 3: duty updates only at wrap; write on wrap edge lands a period later
    wr(5'd0, 32'h0);
    wr(5'd1, 32'd0);
    wr(5'd2, 32'd9);
    wr(5'd8, 32'd3);
    wr(5'd0, 32'h0001_0001);
    e0 = cyc;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) wr(5'd8, 32'd7);
      else if (k == 20) wr(5'd8, 32'd1);
      else step();
      if (k <= 10)      exp_b = (k - 1) < 3;
      else if (k <= 30) exp_b = ((k - 1) % 10) < 7;
      else              exp_b = (k - 31) < 1;
      check($sformatf("s3_pwm_k%0d", k), 32'(pwm_out), 32'({3'b000, exp_b}));
    end

    // Scenario 4: DUTY2=0, DUTY3=15 > PERIOD, POLARITY=0100
    wr(5'd0, 32'h0);
    wr(5'd10, 32'd0);
    wr(5'd11, 32'd15);
    wr(5'd3, 32'h4);
    step();
    check("s4_disabled_pol", 32'(pwm_out), 32'h4);
    wr(5'd0, 32'h000C_0001);
    e0 = cyc;
    check("s4_k0_inactive", 32'(pwm_out), 32'h4);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("s4_pwm_k%0d", k), 32'(pwm_out), 32'hC);
    end
    wr(5'd0, 32'h0);
    check("s4_disable_edge", 32'(pwm_out), 32'hC);
    step();
    check("s4_disabled_after", 32'(pwm_out), 32'h4);
    wr(5'd3, 32'h0);

    // Scenario 5: irq and write-1-to-clear vs. wrap
    wr(5'd8, 32'd3);
    wr(5'd4, 32'h1);
    wr(5'd0, 32'h0001_0003);
    e0 = cyc;
    check("s5_irq_k0", 32'(irq), 32'h0);
    step_to(9);
    check("s5_irq_k9", 32'(irq), 32'h0);
    step();
    check("s5_irq_k10", 32'(irq), 32'h1);
    step_to(13);
    wr(5'd4, 32'h1);
    check("s5_irq_cleared_k14", 32'(irq), 32'h0);
    step_to(19);
    step();
    check("s5_irq_k20", 32'(irq), 32'h1);
    step_to(29);
    wr(5'd4, 32'h1);
    check("s5_set_wins_k30", 32'(irq), 32'h1);
    step();
    check("s5_irq_k31", 32'(irq), 32'h1);
    check("s5_pwm_k31", 32'(pwm_out), 32'h1);

    // Scenario 6: reset mid-period
    rd(5'd0, rdv);                 check("s6_ctrl_rd", rdv, 32'h0001_0003);
    check("s6_pwm_k32", 32'(pwm_out), 32'h1);
    rst = 1'b1;
    #1;
    check("s6_rst_pwm", 32'(pwm_out), 32'h0);
    check("s6_rst_irq", 32'(irq), 32'h0);
    check("s6_rst_rdata", avs_readdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    rd(5'd8, rdv);                 check("s6_duty0_after_rst", rdv, 32'h0);
    rd(5'd0, rdv);                 check("s6_ctrl_after_rst", rdv, 32'h0);
    repeat (12) step();
    check("s6_pwm_idle", 32'(pwm_out), 32'h0);
    check("s6_irq_idle", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of PWM channels (legal range 1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the period counter, PERIOD and DUTY (legal range 2..16).
REQ-003 The block SHALL have these ports, one per line as: name, direction, width, meaning.
- clk_clk  in  1  sole clock.
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  5  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data.
- pwm_out  out  NUM_CH  PWM outputs, registered.
- irq  out  1  period-wrap interrupt.

Function
REQ-004 The register map SHALL be as follows (all other addresses read 0 and ignore writes):
- 0 CTRL: bit0 EN, bit1 IRQ_EN, bits[16+NUM_CH-1:16] CH_EN mask.
- 1 PRESCALE[15:0].
- 2 PERIOD[CNT_W-1:0].
- 3 POLARITY[NUM_CH-1:0].
- 4 STATUS: bit0 WRAP, write-1-to-clear.
- 8+i DUTY[i][CNT_W-1:0].
REQ-005 Register writes SHALL take effect on the clock edge on which avs_write is high; unused bits SHALL read 0.
REQ-006 Read latency SHALL be exactly 1: avs_readdata SHALL be registered, valid on the cycle after avs_read, and hold its value otherwise.
REQ-007 While EN=1, the prescaler SHALL count 0..PRESCALE and assert a one-cycle tick when it equals PRESCALE, then return to 0; PRESCALE=0 SHALL tick every cycle.
REQ-008 On each tick, the counter SHALL increment; when the counter equals the active period, it SHALL wrap to 0 instead.
REQ-009 The PWM period SHALL be (PERIOD+1)*(PRESCALE+1) clocks.
REQ-010 On every wrap, the active period and all active duties SHALL load from the PERIOD/DUTY register values present before that edge, so a write on the wrap cycle takes effect in the following period; there SHALL be no mid-period glitches.
REQ-011 The raw level of channel i SHALL be EN & CH_EN[i] & (counter < active_duty[i]).
REQ-012 DUTY=0 SHALL give a constant inactive level; DUTY>PERIOD SHALL give a constant active level.
REQ-013 pwm_out[i] SHALL equal raw[i] XOR POLARITY[i], registered, one cycle after the counter value that produced it.
REQ-014 While EN=0:
- prescaler and counter SHALL be held at 0;
- the active period and duties SHALL track their registers every cycle;
- pwm_out SHALL equal POLARITY (inactive level).
REQ-015 Setting EN 0->1 SHALL start the counter at 0 with freshly loaded values; the first pwm_out SHALL appear 1 cycle later.
REQ-016 Every wrap SHALL set STATUS.WRAP; a write-1 to STATUS.WRAP on the same cycle as a wrap SHALL leave it set (set wins).
REQ-017 irq SHALL equal STATUS.WRAP AND CTRL.IRQ_EN, taken directly from registers.
REQ-018 Clearing CTRL.EN mid-period SHALL force the inactive level on the next edge with no completion of the current period.

Reset
REQ-019 reset_reset SHALL asynchronously clear all registers, prescaler, counter, active values, STATUS, avs_readdata, and pwm_out to 0; irq SHALL be 0.
REQ-020 After reset release, the first tick SHALL occur only after EN is written to 1.

Structure
REQ-021 The register address localparams, CTRL bit positions, and STATUS bit positions SHALL reside in package pwm_bank_pkg.
REQ-022 Per-channel active-duty shadow, compare, polarity and output register SHALL be sub-module pwm_bank_channel, instantiated NUM_CH times by generate.
REQ-023 Prescaler, counter, register file and bus logic SHALL reside in pwm_bank.

Verification
REQ-024 PERIOD=9, PRESCALE=0, DUTY0=3, EN=1, CH_EN=1 -> pwm_out[0] high 3 of every 10 cycles; WRAP set every 10 cycles.
REQ-025 PRESCALE=4, PERIOD=3, DUTY1=2 -> period 20 clocks, pwm_out[1] high 10 clocks.
REQ-026 Write DUTY0=7 mid-period (old value 3) -> the current period still shows 3 high cycles; the next period shows 7.
REQ-027 DUTY2=0 and DUTY3=15 with PERIOD=9; POLARITY=4'b0100 -> pwm_out[2] constant 1; pwm_out[3] constant 1; EN=0 -> pwm_out=4'b0100.
REQ-028 IRQ_EN=1, wait for a wrap -> irq=1; write STATUS=1 on a non-wrap cycle -> irq=0 next cycle; write STATUS=1 on a wrap cycle -> irq stays 1.
REQ-029 Assert reset_reset mid-period -> pwm_out, irq and avs_readdata go to 0 immediately; a read of address 8 after release -> 0 on the next cycle.
